// File: rtl/bin_to_digits_pkg.sv
// ----------------------------------------------------------------------------
// bin_to_digits_pkg
// Shared definitions for the binary-to-decimal digit converter.
//   state_t        : controller states (IDLE, CONVERT, EMIT)
//   BLANK_CODE     : digit code that makes the glyph stage draw a space
//   ADD3_THRESHOLD : nibble value at or above which double dabble adds 3
//   digit_code()   : plain 8-bit code for a BCD nibble
// ----------------------------------------------------------------------------
package bin_to_digits_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      EMIT    = 2'd2
   } state_t;

   localparam logic [7:0] BLANK_CODE     = 8'hFF;
   localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

   // The glyph stage takes an 8-bit number, so a digit is the nibble
   // zero-extended to a byte.
   function automatic logic [7:0] digit_code(input logic [3:0] nib);
      return {4'h0, nib};
   endfunction

endpackage

// File: rtl/bin_to_digits_bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
// Combinational correction step of the shift-and-add-3 algorithm for one
// BCD nibble: values of 5 or more get 3 added so that the following left
// shift carries correctly into the next decimal digit.
// Ports:
//   nibble_in  : BCD nibble before correction
//   nibble_out : corrected nibble
// ----------------------------------------------------------------------------
module bcd_add3
   import bin_to_digits_pkg::*;
(
   input  logic [3:0] nibble_in,
   output logic [3:0] nibble_out
);

   assign nibble_out = (nibble_in >= ADD3_THRESHOLD) ? (nibble_in + 4'd3) : nibble_in;

endmodule

// File: rtl/bin_to_digits.sv
// ----------------------------------------------------------------------------
// bin_to_digits
// Sequential binary-to-decimal converter feeding the character-glyph stage.
// A start strobe latches bin_in, BIN_W cycles of double dabble build the BCD
// value, then NUM_DIGITS digit codes are sent most-significant first over a
// valid/ready handshake, followed by a one-cycle done pulse.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When defined, zeros ahead of the first nonzero digit are sent as the
//   blank code 8'hFF (the last digit is never blanked). Timing is unchanged.
//
// Ports:
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high reset
//   start        : conversion request, only looked at while busy=0
//   bin_in       : value to convert, latched on an accepted start
//   busy         : conversion or emission in progress (until done pulses)
//   digit_valid  : digit_num / digit_idx hold a digit
//   digit_ready  : consumer takes the digit this cycle
//   digit_num    : 8'h00..8'h09, or 8'hFF for a blanked digit
//   digit_idx    : digit position, 0 = most significant
//   done         : one-cycle pulse after the last digit transfer
// ----------------------------------------------------------------------------
module bin_to_digits
   import bin_to_digits_pkg::*;
#(
   parameter  int BIN_W      = 8,
   parameter  int NUM_DIGITS = 3,
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   output logic             busy,
   output logic             digit_valid,
   input  logic             digit_ready,
   output logic [7:0]       digit_num,
   output logic [IDX_W-1:0] digit_idx,
   output logic             done
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int TOT_W = BCD_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_t             state, state_next;
   logic [BIN_W-1:0]   shift_reg, shift_next;
   logic [BCD_W-1:0]   bcd_reg, bcd_next;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
   logic               busy_next;
   logic               valid_next;
   logic [7:0]         num_next;
   logic [IDX_W-1:0]   idx_next;
   logic               done_next;

   logic [BCD_W-1:0]   bcd_adj;
   logic [TOT_W-1:0]   shifted;
   logic [BCD_W-1:0]   bcd_up;
   logic [3:0]         conv_top;
   logic [3:0]         next_nib;

   // One add-3 corrector per decimal digit of the BCD register.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .nibble_in  (bcd_reg[4*g +: 4]),
         .nibble_out (bcd_adj[4*g +: 4])
      );
   end

   // One double dabble step: corrected BCD and remaining binary shift
   // left together as a single word.
   assign shifted  = {bcd_adj, shift_reg} << 1;
   assign conv_top = shifted[TOT_W-1 -: 4];

   // During EMIT the BCD register moves up one nibble per transfer, so the
   // digit being presented always sits in the top nibble.
   assign bcd_up   = bcd_reg << 4;
   assign next_nib = bcd_up[BCD_W-1 -: 4];

`ifdef LEADING_ZERO_BLANK_EN
   logic       seen_reg, seen_next;
   logic [3:0] cur_nib;

   assign cur_nib = bcd_reg[BCD_W-1 -: 4];

   // A zero is blanked only while no nonzero digit has been sent yet and it
   // is not the units digit, so a value of zero still shows a single 0.
   function automatic logic [7:0] make_code(input logic [3:0] nib,
                                            input logic       seen,
                                            input logic       last);
      if (!seen && !last && (nib == 4'd0))
         return BLANK_CODE;
      return digit_code(nib);
   endfunction
`endif

   // State and datapath registers; everything is computed in the
   // combinational block below and simply captured here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         shift_reg   <= '0;
         bcd_reg     <= '0;
         bit_cnt     <= '0;
         busy        <= 1'b0;
         digit_valid <= 1'b0;
         digit_num   <= 8'h00;
         digit_idx   <= '0;
         done        <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         seen_reg    <= 1'b0;
`endif
      end else begin
         state       <= state_next;
         shift_reg   <= shift_next;
         bcd_reg     <= bcd_next;
         bit_cnt     <= bit_cnt_next;
         busy        <= busy_next;
         digit_valid <= valid_next;
         digit_num   <= num_next;
         digit_idx   <= idx_next;
         done        <= done_next;
`ifdef LEADING_ZERO_BLANK_EN
         seen_reg    <= seen_next;
`endif
      end
   end

   // Next-state and next-output logic.
   // busy stays high through the done cycle (state is already IDLE then),
   // which is why IDLE gates start with busy: a new start is taken one
   // cycle after done.
   always_comb begin
      state_next   = state;
      shift_next   = shift_reg;
      bcd_next     = bcd_reg;
      bit_cnt_next = bit_cnt;
      busy_next    = busy;
      valid_next   = digit_valid;
      num_next     = digit_num;
      idx_next     = digit_idx;
      done_next    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      seen_next    = seen_reg;
`endif

      case (state)
         IDLE: begin
            if (!busy && start) begin
               shift_next   = bin_in;
               bcd_next     = '0;
               bit_cnt_next = '0;
               busy_next    = 1'b1;
               state_next   = CONVERT;
            end else begin
               busy_next    = 1'b0;
            end
         end

         CONVERT: begin
            {bcd_next, shift_next} = shifted;
            bit_cnt_next           = bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
               state_next = EMIT;
               valid_next = 1'b1;
               idx_next   = '0;
`ifdef LEADING_ZERO_BLANK_EN
               seen_next  = 1'b0;
               num_next   = make_code(conv_top, 1'b0, (NUM_DIGITS == 1));
`else
               num_next   = digit_code(conv_top);
`endif
            end
         end

         EMIT: begin
            if (digit_ready) begin
               if (digit_idx == LAST_IDX) begin
                  valid_next = 1'b0;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  idx_next   = digit_idx + IDX_W'(1);
                  bcd_next   = bcd_up;
`ifdef LEADING_ZERO_BLANK_EN
                  seen_next  = seen_reg | (cur_nib != 4'd0);
                  num_next   = make_code(next_nib, seen_reg | (cur_nib != 4'd0),
                                         ((digit_idx + IDX_W'(1)) == LAST_IDX));
`else
                  num_next   = digit_code(next_nib);
`endif
               end
            end
         end

         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            valid_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bin_to_digits.sv
// ----------------------------------------------------------------------------
// tb_bin_to_digits
// Directed bench for bin_to_digits with default parameters. Inputs are driven
// and outputs sampled on the falling edge, so a value seen at a falling edge
// is the one the next rising edge samples. Cycle numbers are counted in
// rising edges after the edge that accepts start (that edge is cycle 0).
// Works in both builds; expected codes follow LEADING_ZERO_BLANK_EN.
// ----------------------------------------------------------------------------
module tb_bin_to_digits;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] bin_in;
   logic       busy;
   logic       digit_valid;
   logic       digit_ready;
   logic [7:0] digit_num;
   logic [1:0] digit_idx;
   logic       done;

   int tests;
   int failures;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [7:0] LZ = 8'hFF;
`else
   localparam logic [7:0] LZ = 8'h00;
`endif

   bin_to_digits #(.BIN_W(8), .NUM_DIGITS(3)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .bin_in      (bin_in),
      .busy        (busy),
      .digit_valid (digit_valid),
      .digit_ready (digit_ready),
      .digit_num   (digit_num),
      .digit_idx   (digit_idx),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one conversion for 30 cycles and records what came out; the
   // scenario tasks compare the records. Caller must be at a falling edge.
   task automatic run_conversion(
      input  logic [7:0]  value,
      input  int          stall_idx,
      input  int          stall_len,
      input  int          extra_at,
      input  logic [7:0]  extra_val,
      output int          first_valid,
      output int          done_cycle,
      output int          busy_low,
      output int          done_count,
      output logic [23:0] codes,
      output logic [5:0]  idxs,
      output int          n_xfer,
      output int          stall_seen,
      output int          hold_errs,
      output logic [7:0]  held_num
   );
      logic [7:0] hold_n;
      logic [1:0] hold_i;
      int         stalls;
      first_valid = -1; done_cycle = -1; busy_low = -1; done_count = 0;
      codes = '0; idxs = '0; n_xfer = 0; stall_seen = 0; hold_errs = 0;
      held_num = 8'h00; hold_n = 8'h00; hold_i = 2'd0; stalls = 0;
      start = 1'b1; bin_in = value; digit_ready = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clock);
         start = 1'b0;
         if (cyc == extra_at) begin
            start  = 1'b1;
            bin_in = extra_val;
         end
         if (digit_valid && first_valid < 0) first_valid = cyc;
         if (done) begin
            done_count++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (!busy && done_cycle >= 0 && busy_low < 0) busy_low = cyc;
         digit_ready = 1'b1;
         if (digit_valid && int'(digit_idx) == stall_idx && stalls < stall_len) begin
            digit_ready = 1'b0;
            if (stalls == 0) begin
               hold_n   = digit_num;
               hold_i   = digit_idx;
               held_num = digit_num;
            end else if (digit_num !== hold_n || digit_idx !== hold_i) begin
               hold_errs++;
            end
            stalls++;
            stall_seen = stalls;
         end
         if (digit_valid && digit_ready) begin
            if (n_xfer < 3) begin
               codes[8*(2-n_xfer) +: 8] = digit_num;
               idxs[2*(2-n_xfer) +: 2]  = digit_idx;
            end
            n_xfer++;
         end
      end
      start = 1'b0;
      digit_ready = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clock);
      reset = 1'b1; start = 1'b0; bin_in = 8'h00; digit_ready = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      tests++; if (digit_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", digit_valid); end
      tests++; if (digit_num !== 8'h00) begin failures++; $display("[TB] FAIL reset_num got %h want 00", digit_num); end
      tests++; if (digit_idx !== 2'd0) begin failures++; $display("[TB] FAIL reset_idx got %0d want 0", digit_idx); end
      tests++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b want 0", done); end
   endtask

   task automatic test_max_value;
      int fv, dc, bl, dn, nx, ss, he;
      logic [23:0] c; logic [5:0] ix; logic [7:0] hn;
      @(negedge clock);
      run_conversion(8'd255, -1, 0, -1, 8'h00, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (fv !== 9) begin failures++; $display("[TB] FAIL max_first_valid got %0d want 9", fv); end
      tests++; if (c !== 24'h020505) begin failures++; $display("[TB] FAIL max_codes got %h want 020505", c); end
      tests++; if (ix !== 6'b00_01_10) begin failures++; $display("[TB] FAIL max_idx got %b want 000110", ix); end
      tests++; if (dc !== 12) begin failures++; $display("[TB] FAIL max_done_cycle got %0d want 12", dc); end
      tests++; if (bl !== 13) begin failures++; $display("[TB] FAIL max_busy_low got %0d want 13", bl); end
      tests++; if (dn !== 1) begin failures++; $display("[TB] FAIL max_done_count got %0d want 1", dn); end
      tests++; if (nx !== 3) begin failures++; $display("[TB] FAIL max_xfers got %0d want 3", nx); end
   endtask

   task automatic test_zero_value;
      int fv, dc, bl, dn, nx, ss, he;
      logic [23:0] c; logic [5:0] ix; logic [7:0] hn;
      @(negedge clock);
      run_conversion(8'd0, -1, 0, -1, 8'h00, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (c !== {LZ, LZ, 8'h00}) begin failures++; $display("[TB] FAIL zero_codes got %h want %h", c, {LZ, LZ, 8'h00}); end
      tests++; if (fv !== 9) begin failures++; $display("[TB] FAIL zero_first_valid got %0d want 9", fv); end
      tests++; if (dc !== 12) begin failures++; $display("[TB] FAIL zero_done_cycle got %0d want 12", dc); end
   endtask

   task automatic test_blanking;
      int fv, dc, bl, dn, nx, ss, he;
      logic [23:0] c; logic [5:0] ix; logic [7:0] hn;
      @(negedge clock);
      run_conversion(8'd105, -1, 0, -1, 8'h00, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (c !== 24'h010005) begin failures++; $display("[TB] FAIL blank_105 got %h want 010005", c); end
      @(negedge clock);
      run_conversion(8'd40, -1, 0, -1, 8'h00, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (c !== {LZ, 8'h04, 8'h00}) begin failures++; $display("[TB] FAIL blank_40 got %h want %h", c, {LZ, 8'h04, 8'h00}); end
   endtask

   task automatic test_backpressure;
      int fv, dc, bl, dn, nx, ss, he;
      logic [23:0] c; logic [5:0] ix; logic [7:0] hn;
      @(negedge clock);
      run_conversion(8'd7, 1, 5, -1, 8'h00, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (ss !== 5) begin failures++; $display("[TB] FAIL stall_cycles got %0d want 5", ss); end
      tests++; if (hn !== LZ) begin failures++; $display("[TB] FAIL stall_num got %h want %h", hn, LZ); end
      tests++; if (he !== 0) begin failures++; $display("[TB] FAIL stall_hold got %0d changes want 0", he); end
      tests++; if (c !== {LZ, LZ, 8'h07}) begin failures++; $display("[TB] FAIL stall_codes got %h want %h", c, {LZ, LZ, 8'h07}); end
      tests++; if (ix !== 6'b00_01_10) begin failures++; $display("[TB] FAIL stall_idx got %b want 000110", ix); end
      tests++; if (dc !== 17) begin failures++; $display("[TB] FAIL stall_done_cycle got %0d want 17", dc); end
      tests++; if (dn !== 1) begin failures++; $display("[TB] FAIL stall_done_count got %0d want 1", dn); end
   endtask

   task automatic test_ignored_start;
      int fv, dc, bl, dn, nx, ss, he;
      logic [23:0] c; logic [5:0] ix; logic [7:0] hn;
      @(negedge clock);
      run_conversion(8'd12, -1, 0, 3, 8'd99, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (c !== {LZ, 8'h01, 8'h02}) begin failures++; $display("[TB] FAIL ignore_codes got %h want %h", c, {LZ, 8'h01, 8'h02}); end
      tests++; if (dn !== 1) begin failures++; $display("[TB] FAIL ignore_done_count got %0d want 1", dn); end
      tests++; if (nx !== 3) begin failures++; $display("[TB] FAIL ignore_xfers got %0d want 3", nx); end
   endtask

   task automatic test_reset_mid;
      int fv, dc, bl, dn, nx, ss, he;
      int late_done, late_valid;
      logic [23:0] c; logic [5:0] ix; logic [7:0] hn;
      @(negedge clock);
      start = 1'b1; bin_in = 8'd200; digit_ready = 1'b1;
      repeat (4) begin
         @(negedge clock);
         start = 1'b0;
      end
      tests++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midreset_busy_before got %b want 1", busy); end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      tests++; if ({busy, digit_valid, digit_num, digit_idx, done} !== 13'b0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs got busy=%b valid=%b num=%h idx=%0d done=%b want all 0",
                  busy, digit_valid, digit_num, digit_idx, done);
      end
      late_done = 0; late_valid = 0;
      repeat (20) begin
         @(negedge clock);
         if (done) late_done++;
         if (digit_valid) late_valid++;
      end
      tests++; if (late_done !== 0) begin failures++; $display("[TB] FAIL midreset_no_done got %0d pulses want 0", late_done); end
      tests++; if (late_valid !== 0) begin failures++; $display("[TB] FAIL midreset_no_valid got %0d cycles want 0", late_valid); end
      run_conversion(8'd128, -1, 0, -1, 8'h00, fv, dc, bl, dn, c, ix, nx, ss, he, hn);
      tests++; if (c !== 24'h010208) begin failures++; $display("[TB] FAIL after_reset_codes got %h want 010208", c); end
      tests++; if (fv !== 9) begin failures++; $display("[TB] FAIL after_reset_first_valid got %0d want 9", fv); end
      tests++; if (dc !== 12) begin failures++; $display("[TB] FAIL after_reset_done_cycle got %0d want 12", dc); end
   endtask

   // A start held high right through done is taken on the first cycle
   // that busy is low, so the second conversion begins at cycle 13.
   task automatic test_back_to_back;
      int cyc, second_valid;
      @(negedge clock);
      start = 1'b1; bin_in = 8'd255; digit_ready = 1'b1;
      @(negedge clock);
      bin_in = 8'd64;
      second_valid = -1;
      for (cyc = 2; cyc <= 40; cyc++) begin
         @(negedge clock);
         if (cyc == 14) start = 1'b0;
         if (cyc > 13 && digit_valid && second_valid < 0) second_valid = cyc;
      end
      start = 1'b0;
      tests++; if (second_valid !== 22) begin failures++; $display("[TB] FAIL b2b_second_valid got %0d want 22", second_valid); end
   endtask

   initial begin
      tests = 0; failures = 0;
      reset = 1'b1; start = 1'b0; bin_in = 8'h00; digit_ready = 1'b1;
      test_reset;
      test_max_value;
      test_zero_value;
      test_blanking;
      test_backpressure;
      test_ignored_start;
      test_reset_mid;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", tests, failures);
      $finish;
   end

endmodule
